rf_write_arbiter: RTL
=====================

// Module: rf_write_arbiter
// PURPOSE
//  Shares the register file's single write port (rg_wr/write_reg/write_data) between
//  N_REQ writeback requesters, e.g. req0 = ALU writeback, req1 = memory-load writeback.
//  Arbitration is round-robin with a valid/ready handshake per requester.
//  The output stage is registered and feeds the register file directly.
//  Also exports a pending-write mask for decode hazard checks and a stall counter.
// PARAMETERS
//  N_REQ   2   number of requesters (>=2)
//  DATA_W  16  write data width
//  ADDR_W  3   register index width (2**ADDR_W registers)
// PORTS
//  clk        in   1               system clock; all state updates on posedge
//  rst_n      in   1               asynchronous, active-low reset
//  req_valid  in   N_REQ           requester i has a write pending
//  req_addr   in   N_REQ*ADDR_W    target register, slice i = [i*ADDR_W +: ADDR_W]
//  req_data   in   N_REQ*DATA_W    write data, slice i = [i*DATA_W +: DATA_W]
//  req_ready  out  N_REQ           one-hot grant; transfer when valid&ready at posedge
//  freeze     in   1               1 = grant nothing this cycle (debug/stall)
//  rg_wr      out  1               write enable to register file
//  write_reg  out  ADDR_W          register index to register file
//  write_data out  DATA_W          data to register file
//  pending    out  2**ADDR_W       bit r = 1 while the output stage holds a write to r
//  stall_cnt  out  16              saturating count of cycles a valid requester was refused
// BEHAVIOUR
//  Reset (rst_n=0, async): rg_wr=0, write_reg=0, write_data=0, pending=0, stall_cnt=0,
//   rr pointer = 0 (requester 0 has highest priority). req_ready=0 while rst_n=0.
//  Grant (combinational): if freeze=1, req_ready=0. Otherwise req_ready is one-hot on
//   the first valid requester scanning ptr, ptr+1, ... mod N_REQ. req_ready=0 if none valid.
//   req_ready never asserts for a requester with req_valid=0.
//  Round-robin: on a granted transfer from requester g, ptr <= (g+1) mod N_REQ.
//   ptr holds when there is no grant.
//  Output stage (1-cycle latency): at the posedge ending cycle N with grant g, the outputs
//   load rg_wr=1, write_reg=req_addr[g], write_data=req_data[g] for cycle N+1. With no
//   grant, rg_wr<=0 and write_reg/write_data hold their last values.
//   Outputs stay stable across the whole cycle; the register file samples them at negedge.
//  Throughput: one write per cycle, back-to-back grants allowed, no bubbles.
//  pending = rg_wr ? (1 << write_reg) : 0. It is registered-derived, with no combinational
//   path from req_*.
//  Same-address requests: both are granted in successive cycles in round-robin order.
//   The later grant's data is the final register value. No merging.
//  stall_cnt: +1 on each posedge where popcount(req_valid & ~req_ready) >= 1.
//   This includes cycles with freeze=1 and valid requests. It saturates at 16'hFFFF.
//  Requester rule: once req_valid=1, addr/data stay stable until granted
//   (arbiter does not check this).
//  Reset mid-operation: the in-flight output write is dropped (rg_wr->0 immediately).
//   No grant occurs in the first cycle after rst_n deasserts only if req_valid=0 then.
// TESTING
//  1 Reset: drive req_valid=2'b11, rst_n=0 -> rg_wr=0, req_ready=0, pending=0, stall_cnt=0.
//  2 Single write: req0 valid, addr=3, data=16'hBEEF for 1 cycle -> next cycle rg_wr=1,
//    write_reg=3, write_data=BEEF, pending=8'h08; following cycle rg_wr=0, pending=0.
//  3 Contention: both valid for 4 cycles (req0 addr1/0x1111, req1 addr2/0x2222, data held,
//    each deasserts after its grant) -> grants 0 then 1; outputs write 1 then 2 on
//    consecutive cycles; stall_cnt=1.
//  4 Fairness: both continuously valid for 6 cycles -> grants alternate 0,1,0,1,0,1;
//    stall_cnt=6.
//  5 Freeze: req1 valid (addr5, 0xA5A5) with freeze=1 for 3 cycles, then 0 -> no grant and
//    rg_wr=0 during freeze; stall_cnt=3; write to r5 appears 1 cycle after release.
//  6 Async reset mid-write: assert rst_n=0 between posedges while rg_wr=1 -> rg_wr falls
//    immediately without a clock; preload stall_cnt near 16'hFFFF in a separate run and
//    check it saturates.

Source files
------------

// File: rtl/rf_write_arbiter_if.sv
// Writeback bus between the requesters and the register-file write port.
// The arbiter takes the slave view; requesters and the bench take the master view.
interface rf_write_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    freeze;
    logic                    rg_wr;
    logic [ADDR_W-1:0]       write_reg;
    logic [DATA_W-1:0]       write_data;
    logic [2**ADDR_W-1:0]    pending;
    logic [15:0]             stall_cnt;

    modport master (
        output req_valid, req_addr, req_data, freeze,
        input  req_ready, rg_wr, write_reg, write_data, pending, stall_cnt
    );

    modport slave (
        input  req_valid, req_addr, req_data, freeze,
        output req_ready, rg_wr, write_reg, write_data, pending, stall_cnt
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between
// N_REQ writeback requesters, with a registered output stage and stall counter.
module rf_write_arbiter #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    rf_write_arbiter_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int REGS  = 2**ADDR_W;

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              rg_wr_q, rg_wr_d;
    logic [ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;

    logic [N_REQ-1:0]  grant;
    logic              granted;
    logic [PTR_W-1:0]  gnt_idx;

    // Scan ptr, ptr+1, ... mod N_REQ; the first valid requester wins.
    always_comb begin : arbitrate
        logic [PTR_W:0] slot;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant   = '0;
        granted = 1'b0;
        gnt_idx = '0;
        slot    = '0;
        if (rst_n && !bus.freeze) begin
            for (int i = 0; i < N_REQ; i++) begin
                slot = {1'b0, ptr_q} + (PTR_W+1)'(i);
                if (slot >= (PTR_W+1)'(N_REQ)) slot = slot - (PTR_W+1)'(N_REQ);
                if (!granted && bus.req_valid[slot[PTR_W-1:0]]) begin
                    granted = 1'b1;
                    gnt_idx = slot[PTR_W-1:0];
                end
            end
        end
        if (granted) grant[gnt_idx] = 1'b1;
    end

    always_comb begin : next_state
        logic [PTR_W:0] nxt;
        ptr_d        = ptr_q;
        rg_wr_d      = granted;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        stall_cnt_d  = stall_cnt_q;
        nxt          = {1'b0, gnt_idx} + (PTR_W+1)'(1);
        if (granted) begin
            if (nxt == (PTR_W+1)'(N_REQ)) nxt = '0;
            ptr_d = nxt[PTR_W-1:0];
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                write_reg_d  = bus.req_addr[i*ADDR_W +: ADDR_W];
                write_data_d = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
        // Any valid requester left without a grant this cycle counts as a stall.
        if ((|(bus.req_valid & ~grant)) && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= '0;
            rg_wr_q      <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            ptr_q        <= ptr_d;
            rg_wr_q      <= rg_wr_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bus.req_ready  = grant;
    assign bus.rg_wr      = rg_wr_q;
    assign bus.write_reg  = write_reg_q;
    assign bus.write_data = write_data_q;
    assign bus.stall_cnt  = stall_cnt_q;
    // Derived only from output flops, so decode sees no combinational path from req_*.
    assign bus.pending    = rg_wr_q ? (REGS'(1) << write_reg_q) : '0;
endmodule
